// File: rtl/tdm_mux4.sv
// tdm_mux4: four-channel time-division transmitter driving a shared line f
// with a 2-bit slot select {a,b}. B/C/D are snapshotted at each frame boundary
// so a frame is coherent. A is sampled live throughout slot 0.
module tdm_mux4 #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SLOT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] f,
    output logic             a,
    output logic             b,
    output logic             valid,
    output logic             frame_start
);

    localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(SLOT_CYCLES - 1);

    logic [CW-1:0]    cyc_cnt;
    logic [1:0]       slot;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] c_s;
    logic [WIDTH-1:0] d_s;

    logic             at_frame;
    logic             at_slot_end;
    logic [WIDTH-1:0] sel;

    // Frame/slot boundary decode and slot data select.
    always_comb begin
        at_frame    = (slot == 2'd0) && (cyc_cnt == '0);
        at_slot_end = (cyc_cnt == LAST_CYC);
        case (slot)
            2'd0:    sel = A;
            2'd1:    sel = b_s;
            2'd2:    sel = c_s;
            default: sel = d_s;
        endcase
    end

    // Sequencer, snapshot and registered outputs; en low freezes everything but valid/frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt     <= '0;
            slot        <= 2'd0;
            b_s         <= '0;
            c_s         <= '0;
            d_s         <= '0;
            f           <= '0;
            a           <= 1'b0;
            b           <= 1'b0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            {a, b}      <= slot;
            valid       <= 1'b1;
            frame_start <= at_frame;
            f           <= sel;
            if (at_frame) begin
                b_s <= B;
                c_s <= C;
                d_s <= D;
            end
            if (at_slot_end) begin
                cyc_cnt <= '0;
                slot    <= slot + 2'd1;
            end else begin
                cyc_cnt <= cyc_cnt + CW'(1);
            end
        end else begin
            valid       <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tdm_mux4.sv
// tb_tdm_mux4: scoreboard bench for tdm_mux4 (WIDTH=1/SLOT_CYCLES=4 and
// WIDTH=4/SLOT_CYCLES=1 instances) with a bench-side 4-way demux loopback.
module tb_tdm_mux4;

    typedef struct packed {
        logic [3:0] f;
        logic [1:0] ab;
        logic       valid;
        logic       fs;
    } exp_t;

    typedef struct packed {
        logic [9:0] pos;
        logic [3:0] sb;
        logic [3:0] sc;
        logic [3:0] sd;
        logic [3:0] f;
        logic [1:0] ab;
    } mstate_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: WIDTH=1, SLOT_CYCLES=4
    logic       rst1, en1;
    logic [0:0] A1, B1, C1, D1, f1;
    logic       a1, b1, valid1, fs1;

    tdm_mux4 #(.WIDTH(1), .SLOT_CYCLES(4)) dut1 (
        .clk(clk), .rst(rst1), .en(en1),
        .A(A1), .B(B1), .C(C1), .D(D1),
        .f(f1), .a(a1), .b(b1), .valid(valid1), .frame_start(fs1)
    );

    // Instance 2: WIDTH=4, SLOT_CYCLES=1
    logic       rst2, en2;
    logic [3:0] A2, B2, C2, D2, f2;
    logic       a2, b2, valid2, fs2;

    tdm_mux4 #(.WIDTH(4), .SLOT_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst2), .en(en2),
        .A(A2), .B(B2), .C(C2), .D(D2),
        .f(f2), .a(a2), .b(b2), .valid(valid2), .frame_start(fs2)
    );

    // 4-way demux on the instance-2 line
    logic [3:0] dmx [4];
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dmx[i] = ({a2, b2} == 2'(i)) ? f2 : 4'h0;
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    exp_t    q1[$];
    exp_t    q2[$];
    mstate_t m1 = '0;
    mstate_t m2 = '0;

    // Behavioural reference: pos counts clocks within the frame.
    task automatic model_step(input mstate_t mi, input int n, input bit r, input bit e,
                              input logic [3:0] va, input logic [3:0] vb,
                              input logic [3:0] vc, input logic [3:0] vd,
                              output mstate_t mo, output exp_t x);
        int s;
        mo = mi;
        x  = '0;
        if (r) begin
            mo = '0;
        end else if (e) begin
            s       = (int'(mi.pos) / n) % 4;
            x.ab    = 2'(s);
            x.valid = 1'b1;
            x.fs    = (mi.pos == 10'd0);
            case (s)
                0:       x.f = va;
                1:       x.f = mi.sb;
                2:       x.f = mi.sc;
                default: x.f = mi.sd;
            endcase
            if (mi.pos == 10'd0) begin
                mo.sb = vb;
                mo.sc = vc;
                mo.sd = vd;
            end
            mo.pos = 10'((int'(mi.pos) + 1) % (4 * n));
            mo.f   = x.f;
            mo.ab  = x.ab;
        end else begin
            x.f  = mi.f;
            x.ab = mi.ab;
        end
    endtask

    task automatic cycle1(input bit r, input bit e, input logic [3:0] va, input logic [3:0] vb,
                          input logic [3:0] vc, input logic [3:0] vd);
        exp_t    x;
        mstate_t nm;
        rst1 = r; en1 = e;
        A1 = va[0]; B1 = vb[0]; C1 = vc[0]; D1 = vd[0];
        model_step(m1, 4, r, e, 4'(va[0]), 4'(vb[0]), 4'(vc[0]), 4'(vd[0]), nm, x);
        m1 = nm;
        q1.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic cycle2(input bit r, input bit e, input logic [3:0] va, input logic [3:0] vb,
                          input logic [3:0] vc, input logic [3:0] vd);
        exp_t    x;
        mstate_t nm;
        rst2 = r; en2 = e;
        A2 = va; B2 = vb; C2 = vc; D2 = vd;
        model_step(m2, 1, r, e, va, vb, vc, vd, nm, x);
        m2 = nm;
        q2.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        cycle1(1'b1, 1'b1, 4'h1, 4'h1, 4'h1, 4'h1);
        x = q1.pop_front();
        n_total++;
        if ({f1, a1, b1, valid1, fs1} !== 5'b0) begin
            $display("FAIL reset_over_en: got f=%b ab=%b%b v=%b fs=%b want all 0", f1, a1, b1, valid1, fs1);
        end else n_pass++;
        cycle1(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        x = q1.pop_front();
        n_total++;
        if ({f1, a1, b1, valid1, fs1} !== {x.f[0], x.ab, x.valid, x.fs}) begin
            $display("FAIL reset_hold: got f=%b ab=%b%b v=%b fs=%b want 0", f1, a1, b1, valid1, fs1);
        end else n_pass++;
    endtask

    task automatic test_frame();
        exp_t         x;
        logic [15:0]  pat;
        logic [31:0]  fsm;
        pat = '0; fsm = '0;
        for (int k = 0; k < 32; k++) begin
            cycle1(1'b0, 1'b1, 4'h1, 4'h0, 4'h1, 4'h1);
            x = q1.pop_front();
            n_total++;
            if ({f1, a1, b1, valid1, fs1} !== {x.f[0], x.ab, x.valid, x.fs}) begin
                $display("FAIL frame[%0d]: got f=%b ab=%b%b v=%b fs=%b want f=%b ab=%b v=%b fs=%b",
                         k, f1, a1, b1, valid1, fs1, x.f[0], x.ab, x.valid, x.fs);
            end else n_pass++;
            if (k < 16) pat[15-k] = f1;
            fsm[k] = fs1;
        end
        n_total++;
        if (pat !== 16'b1111_0000_1111_1111) begin
            $display("FAIL frame_f_pattern: got %b want 1111000011111111", pat);
        end else n_pass++;
        n_total++;
        if (fsm !== 32'h0001_0001) begin
            $display("FAIL frame_start_cycles: got %h want 00010001", fsm);
        end else n_pass++;
    endtask

    task automatic test_snapshot();
        exp_t       x;
        logic [3:0] c;
        logic       f_fr1, f_fr2;
        f_fr1 = 1'b0; f_fr2 = 1'b1;
        for (int k = 0; k < 32; k++) begin
            c = (k >= 5) ? 4'h0 : 4'h1;
            cycle1(1'b0, 1'b1, 4'h1, 4'h0, c, 4'h1);
            x = q1.pop_front();
            n_total++;
            if ({f1, a1, b1, valid1, fs1} !== {x.f[0], x.ab, x.valid, x.fs}) begin
                $display("FAIL snapshot[%0d]: got f=%b ab=%b%b v=%b fs=%b want f=%b ab=%b v=%b fs=%b",
                         k, f1, a1, b1, valid1, fs1, x.f[0], x.ab, x.valid, x.fs);
            end else n_pass++;
            if (k == 8)  f_fr1 = f1;
            if (k == 24) f_fr2 = f1;
        end
        n_total++;
        if ({f_fr1, f_fr2} !== 2'b10) begin
            $display("FAIL snapshot_slot10: got frame1=%b frame2=%b want 1 0", f_fr1, f_fr2);
        end else n_pass++;
    endtask

    task automatic test_en_gap();
        exp_t        x;
        logic [11:0] post;
        bit          e;
        int          j;
        post = '0; j = 0;
        for (int k = 0; k < 19; k++) begin
            e = !(k >= 10 && k < 13);
            cycle1(1'b0, e, 4'h1, 4'h0, 4'h1, 4'h1);
            x = q1.pop_front();
            n_total++;
            if ({f1, a1, b1, valid1, fs1} !== {x.f[0], x.ab, x.valid, x.fs}) begin
                $display("FAIL en_gap[%0d]: got f=%b ab=%b%b v=%b fs=%b want f=%b ab=%b v=%b fs=%b",
                         k, f1, a1, b1, valid1, fs1, x.f[0], x.ab, x.valid, x.fs);
            end else n_pass++;
            if (!e) begin
                n_total++;
                if ({f1, a1, b1, valid1} !== 4'b1100) begin
                    $display("FAIL en_gap_frozen[%0d]: got f=%b ab=%b%b v=%b want f=1 ab=10 v=0",
                             k, f1, a1, b1, valid1);
                end else n_pass++;
            end
            if (k >= 13) begin
                post[11-2*j -: 2] = {a1, b1};
                j++;
            end
        end
        n_total++;
        if (post !== 12'b10_10_11_11_11_11) begin
            $display("FAIL en_gap_resume: got %b want 101011111111", post);
        end else n_pass++;
    endtask

    task automatic test_mid_reset();
        exp_t       x;
        logic [3:0] va;
        for (int k = 0; k < 13; k++) begin
            va = (k < 4) ? 4'((k + 1) % 2) : 4'h1;
            cycle1(1'b0, 1'b1, va, 4'h0, 4'h1, 4'h1);
            x = q1.pop_front();
            n_total++;
            if ({f1, a1, b1, valid1, fs1} !== {x.f[0], x.ab, x.valid, x.fs}) begin
                $display("FAIL pre_reset[%0d]: got f=%b ab=%b%b v=%b fs=%b want f=%b ab=%b v=%b fs=%b",
                         k, f1, a1, b1, valid1, fs1, x.f[0], x.ab, x.valid, x.fs);
            end else n_pass++;
        end
        cycle1(1'b1, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0);
        x = q1.pop_front();
        n_total++;
        if ({f1, a1, b1, valid1, fs1} !== 5'b0) begin
            $display("FAIL mid_reset: got f=%b ab=%b%b v=%b fs=%b want all 0", f1, a1, b1, valid1, fs1);
        end else n_pass++;
        // Fresh frame: B now 1 must appear in slot 01
        for (int k = 0; k < 8; k++) begin
            va = (k == 0) ? 4'h0 : 4'h1;
            cycle1(1'b0, 1'b1, va, 4'h1, 4'h0, 4'h0);
            x = q1.pop_front();
            n_total++;
            if ({f1, a1, b1, valid1, fs1} !== {x.f[0], x.ab, x.valid, x.fs}) begin
                $display("FAIL post_reset[%0d]: got f=%b ab=%b%b v=%b fs=%b want f=%b ab=%b v=%b fs=%b",
                         k, f1, a1, b1, valid1, fs1, x.f[0], x.ab, x.valid, x.fs);
            end else n_pass++;
            if (k == 0) begin
                n_total++;
                if ({f1, a1, b1, valid1, fs1} !== 5'b0_00_11) begin
                    $display("FAIL post_reset_first: got f=%b ab=%b%b v=%b fs=%b want f=0 ab=00 v=1 fs=1",
                             f1, a1, b1, valid1, fs1);
                end else n_pass++;
            end
            if (k == 4) begin
                n_total++;
                if ({f1, a1, b1} !== 3'b1_01) begin
                    $display("FAIL post_reset_fresh_b: got f=%b ab=%b%b want f=1 ab=01", f1, a1, b1);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_sc1_loopback();
        exp_t       x;
        logic [3:0] fseq [4];
        fseq[0] = 4'hA; fseq[1] = 4'h5; fseq[2] = 4'h3; fseq[3] = 4'hC;
        cycle2(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        x = q2.pop_front();
        for (int k = 0; k < 13; k++) begin
            cycle2(1'b0, (k < 12), 4'hA, 4'h5, 4'h3, 4'hC);
            x = q2.pop_front();
            n_total++;
            if ({f2, a2, b2, valid2, fs2} !== {x.f, x.ab, x.valid, x.fs}) begin
                $display("FAIL sc1[%0d]: got f=%h ab=%b%b v=%b fs=%b want f=%h ab=%b v=%b fs=%b",
                         k, f2, a2, b2, valid2, fs2, x.f, x.ab, x.valid, x.fs);
            end else n_pass++;
            if (k < 12) begin
                n_total++;
                if ({f2, fs2} !== {fseq[k%4], (k % 4 == 0)}) begin
                    $display("FAIL sc1_seq[%0d]: got f=%h fs=%b want f=%h fs=%b",
                             k, f2, fs2, fseq[k%4], (k % 4 == 0));
                end else n_pass++;
                for (int i = 0; i < 4; i++) begin
                    n_total++;
                    if (dmx[i] !== ((2'(i) == x.ab) ? x.f : 4'h0)) begin
                        $display("FAIL loopback[%0d] out%0d: got %h want %h",
                                 k, i, dmx[i], (2'(i) == x.ab) ? x.f : 4'h0);
                    end else n_pass++;
                end
            end
        end
    endtask

    initial begin
        rst2 = 1'b1; en2 = 1'b0;
        A2 = '0; B2 = '0; C2 = '0; D2 = '0;
        test_reset();
        test_frame();
        test_snapshot();
        test_en_gap();
        test_mid_reset();
        test_sc1_loopback();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
